// File: rtl/ide_cycle_pkg.sv
// Shared constants for the IDE strobe sequencer: state codes, window base and
// default PIO timing (also used by the fast-RAM decode to keep windows disjoint).
package ide_cycle_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_ACK    = 3'd4;

  localparam logic [7:0] IDE_BASE_DEF   = 8'hDA;
  localparam int         SETUP_CYC_DEF  = 2;
  localparam int         STROBE_CYC_DEF = 6;
  localparam int         HOLD_CYC_DEF   = 2;
  localparam int         CNT_W_DEF      = 4;
  localparam logic [7:0] IORDY_TMO      = 8'hFF;

  // Registered bus-side outputs, all active low.
  typedef struct packed {
    logic [1:0] cs;
    logic       ior;
    logic       iow;
    logic       dbuf_oe;
    logic       ready;
  } ide_out_t;

  localparam ide_out_t OUT_IDLE = 6'b11_1111;

  // Counter reload for a phase; a zero-length phase still lasts one cycle.
  function automatic int phase_load(input int cyc);
    return (cyc < 1) ? 0 : cyc - 1;
  endfunction

endpackage

// File: rtl/ide_int_sync.sv
// Multi-flop synchroniser with inverted output, for asynchronous
// active-high inputs that must appear as active-low requests.
module ide_int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout_n
);

  logic [STAGES-1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[STAGES-2:0], din};
  end

  assign dout_n = ~sync_pipe[STAGES-1];

endmodule

// File: rtl/ide_cycle.sv
// PIO-mode IDE strobe sequencer: window decode, CS/IOR/IOW timing, ready flag
// and INT2 synchronisation. Define IDE_IORDY_EN to add IORDY strobe stretching.
module ide_cycle
  import ide_cycle_pkg::*;
#(
  parameter logic [7:0] IDE_BASE   = IDE_BASE_DEF,
  parameter int         SETUP_CYC  = SETUP_CYC_DEF,
  parameter int         STROBE_CYC = STROBE_CYC_DEF,
  parameter int         HOLD_CYC   = HOLD_CYC_DEF,
  parameter int         CNT_W      = CNT_W_DEF
) (
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic [23:0] A,
  input  logic        AS20,
  input  logic        DS20,
  input  logic        RW20,
  input  logic        IDEINT,
`ifdef IDE_IORDY_EN
  input  logic        IORDY,
`endif
  output logic        IDE_ACCESS,
  output logic        IDE_READY,
  output logic [1:0]  IDECS,
  output logic        IOR,
  output logic        IOW,
  output logic        DBUF_OE,
  output logic        INT2
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(phase_load(SETUP_CYC));
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(phase_load(STROBE_CYC));
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(phase_load(HOLD_CYC));

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             rd_q;
  logic             abort;
  logic             strobe_done;
  ide_out_t         out_q;

  // Data strobe and low address bits play no part in the decode.
  logic unused_bits;
  assign unused_bits = ^{A[15:13], A[11:0], DS20};

  assign IDE_ACCESS = ~((A[23:16] == IDE_BASE) & ~AS20);

`ifdef IDE_IORDY_EN
  logic [7:0] wait_cnt;
  always_comb strobe_done = (cnt == '0) && (IORDY || wait_cnt == IORDY_TMO);
`else
  always_comb strobe_done = (cnt == '0);
`endif

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rd_q  <= 1'b1;
      abort <= 1'b0;
      out_q <= OUT_IDLE;
`ifdef IDE_IORDY_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (!IDE_ACCESS) begin
          rd_q          <= RW20;
          abort         <= 1'b0;
          cnt           <= SETUP_LD;
          out_q.cs      <= A[12] ? 2'b01 : 2'b10;
          out_q.dbuf_oe <= 1'b0;
          state         <= ST_SETUP;
        end
        ST_SETUP: begin
          abort <= abort | AS20;
          if (cnt == '0) begin
            out_q.ior <= ~rd_q;
            out_q.iow <= rd_q;
            cnt       <= STROBE_LD;
            state     <= ST_STROBE;
`ifdef IDE_IORDY_EN
            wait_cnt  <= '0;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          abort <= abort | AS20;
          if (strobe_done) begin
            out_q.ior <= 1'b1;
            out_q.iow <= 1'b1;
            cnt       <= HOLD_LD;
            state     <= ST_HOLD;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
`ifdef IDE_IORDY_EN
          // Drive not ready: hold the strobe low, bounded by the timeout.
          else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_HOLD: begin
          abort <= abort | AS20;
          if (cnt == '0) begin
            out_q.cs      <= 2'b11;
            out_q.dbuf_oe <= 1'b1;
            // A cycle the CPU abandoned is never acknowledged.
            if (abort || AS20) begin
              state <= ST_IDLE;
            end else begin
              out_q.ready <= 1'b0;
              state       <= ST_ACK;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ACK: if (AS20) begin
          out_q.ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign IDECS     = out_q.cs;
  assign IOR       = out_q.ior;
  assign IOW       = out_q.iow;
  assign DBUF_OE   = out_q.dbuf_oe;
  assign IDE_READY = out_q.ready;

  ide_int_sync #(.STAGES(2)) u_int_sync (
    .clk    (CLKCPU),
    .rst    (RESET),
    .din    (IDEINT),
    .dout_n (INT2)
  );

endmodule

// File: tb/tb_ide_cycle.sv
// Directed bench for ide_cycle: per-edge expected outputs are queued from a
// timing model when each access is issued and popped as each edge completes.
module tb_ide_cycle;

  logic        CLKCPU = 1'b0;
  logic        RESET  = 1'b1;
  logic [23:0] A      = 24'h0;
  logic        AS20   = 1'b1;
  logic        DS20   = 1'b1;
  logic        RW20   = 1'b1;
  logic        IDEINT = 1'b0;
  logic        IDE_ACCESS, IDE_READY, IOR, IOW, DBUF_OE, INT2;
  logic [1:0]  IDECS;

  int total = 0;
  int bad   = 0;

  logic [5:0] sb[$];
  logic       sb_int[$];

  localparam logic [5:0] IDLE_V = 6'b11_1111;

  ide_cycle dut (
    .CLKCPU(CLKCPU), .RESET(RESET), .A(A), .AS20(AS20), .DS20(DS20),
    .RW20(RW20), .IDEINT(IDEINT), .IDE_ACCESS(IDE_ACCESS),
    .IDE_READY(IDE_READY), .IDECS(IDECS), .IOR(IOR), .IOW(IOW),
    .DBUF_OE(DBUF_OE), .INT2(INT2)
  );

  always #5 CLKCPU = ~CLKCPU;

  function automatic logic [5:0] obs_vec();
    return {IDECS, IOR, IOW, DBUF_OE, IDE_READY};
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected {IDECS,IOR,IOW,DBUF_OE,IDE_READY} after edge k of an access
  // presented before edge 1, at default timing (2/6/2).
  function automatic logic [5:0] model(input logic [23:0] addr, input logic rd,
                                       input int as_hi, input int rst_at, input int k);
    logic       abort_c, strb;
    logic [1:0] cs;
    if (addr[23:16] != 8'hDA || (rst_at > 0 && k >= rst_at)) return IDLE_V;
    abort_c = (as_hi <= 11);
    strb    = (k >= 3 && k <= 8);
    cs      = (k <= 10) ? (addr[12] ? 2'b01 : 2'b10) : 2'b11;
    return {cs, ~(strb & rd), ~(strb & ~rd), ~(k <= 10),
            ~(!abort_c && k >= 11 && k < as_hi)};
  endfunction

  // as_hi: first edge that samples AS20 high; rst_at: edge that samples RESET.
  task automatic access(input string tag, input logic [23:0] addr, input logic rd,
                        input int as_hi, input int rst_at, input int n);
    for (int k = 1; k <= n; k++) sb.push_back(model(addr, rd, as_hi, rst_at, k));
    sb.push_back(IDLE_V);
    @(negedge CLKCPU);
    A = addr; RW20 = rd; AS20 = 1'b0; DS20 = 1'b0;
    #1 check({tag, "_decode"}, {5'b0, IDE_ACCESS}, {5'b0, addr[23:16] != 8'hDA});
    for (int k = 1; k <= n; k++) begin
      if (k > 1) @(negedge CLKCPU);
      if (k >= as_hi) begin AS20 = 1'b1; DS20 = 1'b1; end
      if (k == rst_at) RESET = 1'b1;
      @(posedge CLKCPU); #1;
      check($sformatf("%s_e%0d", tag, k), obs_vec(), sb.pop_front());
    end
    @(negedge CLKCPU);
    RESET = 1'b0; AS20 = 1'b1; DS20 = 1'b1;
    @(posedge CLKCPU); #1;
    check({tag, "_idle"}, obs_vec(), sb.pop_front());
  endtask

  initial begin
    repeat (2) @(posedge CLKCPU);
    #1;
    check("reset_outs", obs_vec(), IDLE_V);
    check("reset_int2", {5'b0, INT2}, 6'd1);
    @(negedge CLKCPU); RESET = 1'b0;

    access("rd_cs0",  24'hDA2000, 1'b1, 14, 0, 15);
    access("wr_cs1",  24'hDA3000, 1'b0, 13, 0, 14);
    access("non_ide", 24'hDB0000, 1'b1, 20, 0, 12);
    access("abort",   24'hDA2000, 1'b1, 5,  0, 13);
    access("after_ab",24'hDA2000, 1'b0, 12, 0, 13);
    access("rst_mid", 24'hDA3000, 1'b1, 99, 6, 6);
    access("after_rs",24'hDA2000, 1'b1, 14, 0, 15);

    // IDEINT high for 5 sampled edges: INT2 low after edges 2..6.
    for (int k = 1; k <= 9; k++) sb_int.push_back(!(k >= 2 && k <= 6));
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLKCPU);
      IDEINT = (k <= 5);
      @(posedge CLKCPU); #1;
      check($sformatf("int2_e%0d", k), {5'b0, INT2}, {5'b0, sb_int.pop_front()});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ide_cycle.md
Name: ide_cycle

Overview:
- PIO-mode IDE strobe sequencer for the CD32 expansion CPLD.
- Sits beside the fast-RAM controller, on the 68EC020 bus side.
- Decodes the IDE window, produces chip-select/IOR/IOW with programmable setup/strobe/hold, and returns a ready flag that the top level merges into DSACK.
- Also synchronises the drive interrupt onto INT2.

Parameters:
- IDE_BASE, 8'hDA: A[23:16] match for the IDE window.
- SETUP_CYC, 2: CLKCPU cycles of address/CS setup before the strobe asserts.
- STROBE_CYC, 6: CLKCPU cycles IOR/IOW are held low.
- HOLD_CYC, 2: CLKCPU cycles of CS/address hold after the strobe negates.
- CNT_W, 4: timing counter width; every *_CYC must be ≤ 2^CNT_W−1.

Ports:
- CLKCPU  in  1  CPU clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- A  in  24  CPU address.
- AS20  in  1  address strobe, active low.
- DS20  in  1  data strobe, active low.
- RW20  in  1  1 = read, 0 = write.
- IDEINT  in  1  drive INTRQ, active high, asynchronous.
- IDE_ACCESS  out  1  0 = current cycle decoded as IDE (combinational: A[23:16]==IDE_BASE & ~AS20).
- IDE_READY  out  1  0 = terminate cycle (top drives DSACK[1] low).
- IDECS  out  2  CS1/CS0, active low; CS0 selected when A[12]=0, CS1 when A[12]=1.
- IOR  out  1  read strobe, active low.
- IOW  out  1  write strobe, active low.
- DBUF_OE  out  1  data buffer enable, active low; low from SETUP through HOLD.
- INT2  out  1  active-low interrupt request to the host.

Behaviour:
- Reset values (registered outputs): IDECS=2'b11, IOR=1, IOW=1, IDE_READY=1, DBUF_OE=1, INT2=1, state=IDLE, counter=0.
- IDLE:
  - On an edge where IDE_ACCESS=0: latch RW20 and A[12], load counter with SETUP_CYC−1, drive IDECS and DBUF_OE=0, go to SETUP.
- SETUP:
  - Counter decrements each edge.
  - At 0: assert IOR (latched RW=1) or IOW (RW=0), load STROBE_CYC−1, go to STROBE.
- STROBE:
  - Counter decrements; at 0: negate strobe, load HOLD_CYC−1, go to HOLD.
  - Read data is sampled externally on the strobe's rising edge.
- HOLD:
  - At 0: negate IDECS and DBUF_OE, set IDE_READY=0, go to ACK.
- ACK:
  - IDE_READY stays 0 until AS20 is sampled high.
  - Then IDE_READY=1 and the block returns to IDLE.
  - A new cycle cannot start in the same edge that AS20 rises.
- Total latency, IDE_ACCESS low to IDE_READY low = 1+SETUP_CYC+STROBE_CYC+HOLD_CYC edges (11 at defaults).
- Abort: AS20 high while in SETUP/STROBE/HOLD.
  - Sequence still completes (drive timing is protected).
  - IDE_READY is never asserted; the block returns to IDLE after HOLD.
- A *_CYC value of 0 is treated as 1; every phase lasts at least one cycle.
- IOR and IOW are never low simultaneously; the latched RW is not re-sampled mid-cycle.
- INT2 = ~IDEINT after a two-flop synchroniser (2-edge latency); the synchroniser is reset to 0.
- RESET asserted mid-cycle: all outputs return to reset values on the next edge, with no glitch pulse on IOR/IOW.

Optional Feature:
- IDE_IORDY_EN defined:
  - Adds input IORDY (1 = ready).
  - In STROBE with counter==0 and IORDY sampled 0, the block stays in STROBE with the strobe held low.
  - Timeout after 255 extra cycles forces the transition to HOLD.
- Undefined: the port is absent and the strobe length is fixed at STROBE_CYC.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, SETUP, STROBE, HOLD, ACK)
  - IDE_BASE default
  - default timing constants, shared with the fast-RAM decode so the address windows stay disjoint.
- Natural sub-module: ide_int_sync (two-flop synchroniser plus inversion), reusable for other async inputs.

Test Plan:
- Read at 0xDA2000, A[12]=0, defaults → IDECS=2'b10 at edge 1, IOR low edges 3–8, IOW stays 1, IDE_READY low at edge 11 until AS20 rises.
- Write at 0xDA3000 → IDECS=2'b01, IOW low for exactly 6 cycles, IOR stays 1, DBUF_OE low edges 1–10.
- Access at 0xDB0000 → IDE_ACCESS=1, no CS or strobe activity, IDE_READY stays 1.
- AS20 negated during STROBE → strobe still lasts 6 cycles, HOLD completes, IDE_READY never 0, state=IDLE afterwards.
- RESET pulsed during STROBE → next edge: IOR=1, IDECS=2'b11, state IDLE; the following access runs normal timing.
- IDEINT pulse of 5 cycles → INT2 low for 5 cycles, starting 2 edges later; with IDE_IORDY_EN, IORDY=0 for 10 extra cycles → strobe is 16 cycles long.
